multdiv_sequencer: RTL

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/multdiv_sequencer.sv
// Sequences mul/div instructions through an external multdiv unit.
// Recognises a mul/div in the current instruction word and stalls fetch.
// Starts the unit, waits for its result (bounded by TIMEOUT cycles), then
// writes the result back. On an exception or timeout, it writes the
// exception code to r30 instead.
//
// Handshake: md_start_mult / md_start_div are single-cycle pulses.
// md_ready is a single-cycle result-valid strobe that qualifies
// md_result and md_exception. It is only sampled in WAIT. No ready is
// returned to the unit; a strobe that arrives outside WAIT is dropped.
module multdiv_sequencer #(
  parameter int TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] q_imem,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic        stall,
  output logic        wb_en,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        timeout_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  localparam logic [5:0] LAST_WAIT = 6'(TIMEOUT - 1);
  localparam logic [4:0] ALU_MUL   = 5'b00110;
  localparam logic [4:0] ALU_DIV   = 5'b00111;
  localparam logic [4:0] EXC_REG   = 5'd30;

  state_t      state;
  logic [4:0]  rd_q;
  logic        op_q;       // 0 = mul, 1 = div
  logic [31:0] result_q;
  logic        exc_q;
  logic [5:0]  count_q;
  logic        timeout_q;
  logic        is_md;

  // Only the opcode, rd and ALUop fields matter to this block.
  logic unused_imem_bits;
  assign unused_imem_bits = ^{q_imem[21:7], q_imem[1:0]};

  // Decode a mul/div from the instruction currently presented.
  always_comb begin
    is_md = (q_imem[31:27] == 5'b00000) &&
            ((q_imem[6:2] == ALU_MUL) || (q_imem[6:2] == ALU_DIV));
  end

  // Sequencer FSM: capture the instruction, start the unit, wait with timeout, write back.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      rd_q      <= 5'd0;
      op_q      <= 1'b0;
      result_q  <= 32'd0;
      exc_q     <= 1'b0;
      count_q   <= 6'd0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_md) begin
            rd_q  <= q_imem[26:22];
            op_q  <= q_imem[2];
            state <= S_START;
          end
        end
        S_START: begin
          count_q <= 6'd0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          count_q <= count_q + 6'd1;
          // A result arriving on the final cycle still wins over the timeout.
          if (md_ready) begin
            result_q <= md_result;
            exc_q    <= md_exception;
            state    <= S_WB;
          end else if (count_q == LAST_WAIT) begin
            exc_q     <= 1'b1;
            timeout_q <= 1'b1;
            state     <= S_WB;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded from registered state only, except the IDLE stall which must track the fetched word.
  always_comb begin
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    stall         = 1'b0;
    wb_en         = 1'b0;
    wb_rd         = 5'd0;
    wb_data       = 32'd0;
    case (state)
      S_IDLE:  stall = is_md;
      S_START: begin
        stall         = 1'b1;
        md_start_mult = ~op_q;
        md_start_div  = op_q;
      end
      S_WAIT:  stall = 1'b1;
      S_WB: begin
        if (exc_q) begin
          wb_en   = 1'b1;
          wb_rd   = EXC_REG;
          wb_data = op_q ? 32'd5 : 32'd4;
        end else begin
          wb_en   = (rd_q != 5'd0);
          wb_rd   = rd_q;
          wb_data = result_q;
        end
      end
      default: stall = 1'b0;
    endcase
  end

  assign timeout_err = timeout_q;
  assign dbg_state   = state;

endmodule
